// File: rtl/uart_pkg.sv
// Shared UART definitions: RX deframer state encoding, oversampling
// constants and register-file addresses used by the UART top.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    localparam logic [7:0] TX_DATA_ADDR  = 8'h00;
    localparam logic [7:0] RX_DATA_ADDR  = 8'h04;
    localparam logic [7:0] FREQ_DIV_ADDR = 8'h08;

    // True on the last oversample slot of a bit period.
    function automatic logic last_sample(input logic [3:0] cnt);
        return cnt == 4'(OVERSAMPLE - 1);
    endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Signal bundle between the RX deframer and its surroundings.
//   rx_bit       serial line in (asynchronous, idles high)
//   freq_divider 16x tick period minus 1, in clk cycles
//   fifo_full    RX FIFO full flag
//   rx_data      received byte, valid with rx_push
//   rx_push      one-cycle push strobe to the RX FIFO
//   frame_err    one-cycle pulse, stop bit sampled low
//   overrun      one-cycle pulse, good byte dropped on full FIFO
//   busy         deframer not idle
// master: drives the line/config side; slave: the deframer.
interface uart_rx_frontend_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_bit;
    logic [7:0]           freq_divider;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_push;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_bit, freq_divider, fifo_full,
        input  rx_data, rx_push, frame_err, overrun, busy
    );

    modport slave (
        input  rx_bit, freq_divider, fifo_full,
        output rx_data, rx_push, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator, shareable between RX and TX.
//   clk, reset      system clock, synchronous active-high reset
//   i_freq_divider  tick period minus 1, in clk cycles
//   o_tick          one-clk tick every i_freq_divider+1 clks
module uart_baud_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_freq_divider,
    output logic       o_tick
);
    logic [7:0] r_count;

    // >= rather than == so a divider lowered mid-count ticks on the next
    // cycle instead of wrapping through 255.
    assign o_tick = (r_count >= i_freq_divider);

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= 8'd0;
        else if (o_tick)
            r_count <= 8'd0;
        else
            r_count <= r_count + 8'd1;
    end
endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive deframer: 8N1, 16x oversampling, mid-bit sampling.
//   clk, reset  system clock, synchronous active-high reset
//   rx_if       slave side of uart_rx_frontend_if (line, divider,
//               FIFO full in; data/push/frame_err/overrun/busy out)
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 8
) (
    input  logic                clk,
    input  logic                reset,
    uart_rx_frontend_if.slave   rx_if
);
    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    logic                   w_tick;

    rx_state_e              r_state,  w_state_nxt;
    logic [3:0]             r_cnt,    w_cnt_nxt;
    logic [2:0]             r_idx,    w_idx_nxt;
    logic [DATA_BITS-1:0]   r_shift,  w_shift_nxt;
    logic [DATA_BITS-1:0]   r_rx_data, w_rx_data_nxt;
    logic                   r_push,   w_push_nxt;
    logic                   r_frame_err, w_frame_err_nxt;
    logic                   r_overrun,   w_overrun_nxt;

    // Synchronizer resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset)
            r_sync <= '1;
        else
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_if.rx_bit};
    end
    assign w_rx_s = r_sync[SYNC_STAGES-1];

    uart_baud_tick u_baud_tick (
        .clk            (clk),
        .reset          (reset),
        .i_freq_divider (rx_if.freq_divider),
        .o_tick         (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= 3'd0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_push      <= w_push_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_rx_data_nxt   = r_rx_data;
        w_push_nxt      = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                START: begin
                    // Re-check the line half a bit after the edge to reject glitches.
                    if (r_cnt == 4'(MID_SAMPLE)) begin
                        if (!w_rx_s) begin
                            w_state_nxt = DATA;
                            w_cnt_nxt   = 4'd0;
                            w_idx_nxt   = 3'd0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (last_sample(r_cnt)) begin
                        w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_cnt_nxt   = 4'd0;
                        if (r_idx == IDX_LAST)
                            w_state_nxt = STOP;
                        else
                            w_idx_nxt = r_idx + 3'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (last_sample(r_cnt)) begin
                        w_cnt_nxt = 4'd0;
                        if (w_rx_s) begin
                            w_state_nxt = IDLE;
                            if (!rx_if.fifo_full) begin
                                w_push_nxt    = 1'b1;
                                w_rx_data_nxt = r_shift;
                            end else begin
                                w_overrun_nxt = 1'b1;
                            end
                        end else begin
                            w_frame_err_nxt = 1'b1;
                            w_state_nxt     = BREAK;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so it yields one error, not a stream.
                    if (w_rx_s)
                        w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign rx_if.rx_data   = r_rx_data;
    assign rx_if.rx_push   = r_push;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.overrun   = r_overrun;
    assign rx_if.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_frontend.sv
module tb_uart_rx_frontend;
    import uart_pkg::*;

    logic clk;
    logic reset;

    uart_rx_frontend_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_frontend #(.SYNC_STAGES(2), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state: running totals only, tests work on deltas.
    int         cyc = 0;
    int         push_tot = 0;
    int         ferr_tot = 0;
    int         ovr_tot = 0;
    int         excl_viol = 0;
    int         busy_low_tot = 0;
    int         busy_high_tot = 0;
    int         push_cyc = 0;
    logic [7:0] rx_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_if.rx_push) begin
            push_tot = push_tot + 1;
            push_cyc = cyc;
            rx_log.push_back(rx_if.rx_data);
        end
        if (rx_if.frame_err) ferr_tot = ferr_tot + 1;
        if (rx_if.overrun)   ovr_tot  = ovr_tot + 1;
        if ((int'(rx_if.rx_push) + int'(rx_if.frame_err) + int'(rx_if.overrun)) > 1)
            excl_viol = excl_viol + 1;
        if (rx_if.busy) busy_high_tot = busy_high_tot + 1;
        else            busy_low_tot  = busy_low_tot + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame, LSB first, cpb clks per bit; stop level selectable.
    task automatic send_byte(input logic [7:0] d, input logic stop_lvl, input int cpb);
        rx_if.rx_bit = 1'b0;
        wait_clks(cpb);
        for (int i = 0; i < 8; i++) begin
            rx_if.rx_bit = d[i];
            wait_clks(cpb);
        end
        rx_if.rx_bit = stop_lvl;
        wait_clks(cpb);
    endtask

    int p0, f0, o0, b0, bh0, t0, lat;

    initial begin
        reset              = 1'b1;
        rx_if.rx_bit       = 1'b0;
        rx_if.freq_divider = 8'd0;
        rx_if.fifo_full    = 1'b0;

        // Reset held with the line low.
        wait_clks(3);
        check("rst_rx_data",   32'(rx_if.rx_data),   32'h00);
        check("rst_rx_push",   32'(rx_if.rx_push),   32'h0);
        check("rst_frame_err", 32'(rx_if.frame_err), 32'h0);
        check("rst_overrun",   32'(rx_if.overrun),   32'h0);
        check("rst_busy",      32'(rx_if.busy),      32'h0);
        check("rst_no_strobe", 32'(push_tot + ferr_tot + ovr_tot), 32'd0);
        rx_if.rx_bit = 1'b1;
        reset = 1'b0;
        bh0 = busy_high_tot;
        wait_clks(20);
        check("post_rst_busy", 32'(busy_high_tot - bh0), 32'd0);

        // Single byte 0xA5 at divider 0.
        p0 = push_tot; f0 = ferr_tot; o0 = ovr_tot;
        t0 = cyc;
        send_byte(8'hA5, 1'b1, 16);
        wait_clks(20);
        check("a5_push_cnt", 32'(push_tot - p0), 32'd1);
        check("a5_data",     32'(rx_log[p0]),    32'hA5);
        check("a5_ferr",     32'(ferr_tot - f0), 32'd0);
        check("a5_ovr",      32'(ovr_tot - o0),  32'd0);
        lat = push_cyc - t0;
        check("a5_latency_in_152_156", 32'(lat >= 152 && lat <= 156), 32'd1);

        // 4-clk glitch is rejected.
        p0 = push_tot; f0 = ferr_tot; o0 = ovr_tot;
        rx_if.rx_bit = 1'b0;
        wait_clks(4);
        rx_if.rx_bit = 1'b1;
        wait_clks(12);
        check("glitch_busy",    32'(rx_if.busy), 32'h0);
        check("glitch_strobes", 32'((push_tot - p0) + (ferr_tot - f0) + (ovr_tot - o0)), 32'd0);

        // Framing error followed by a held-low line.
        p0 = push_tot; f0 = ferr_tot;
        send_byte(8'h3C, 1'b0, 16);
        b0 = busy_low_tot;
        wait_clks(400);
        check("ferr_cnt",       32'(ferr_tot - f0),     32'd1);
        check("ferr_no_push",   32'(push_tot - p0),     32'd0);
        check("ferr_busy_held", 32'(busy_low_tot - b0), 32'd0);
        rx_if.rx_bit = 1'b1;
        wait_clks(20);
        check("break_exit_busy", 32'(rx_if.busy), 32'h0);
        send_byte(8'h81, 1'b1, 16);
        wait_clks(20);
        check("after_break_push", 32'(push_tot - p0), 32'd1);
        check("after_break_data", 32'(rx_log[p0]),    32'h81);
        check("after_break_ferr", 32'(ferr_tot - f0), 32'd1);

        // Overrun on full FIFO, then the same frame accepted.
        p0 = push_tot; o0 = ovr_tot; f0 = ferr_tot;
        rx_if.fifo_full = 1'b1;
        send_byte(8'h7E, 1'b1, 16);
        wait_clks(20);
        rx_if.fifo_full = 1'b0;
        check("ovr_cnt",     32'(ovr_tot - o0),  32'd1);
        check("ovr_no_push", 32'(push_tot - p0), 32'd0);
        send_byte(8'h7E, 1'b1, 16);
        wait_clks(20);
        check("ovr_then_push", 32'(push_tot - p0), 32'd1);
        check("ovr_then_data", 32'(rx_log[p0]),    32'h7E);
        check("ovr_cnt_final", 32'(ovr_tot - o0),  32'd1);
        check("ovr_no_ferr",   32'(ferr_tot - f0), 32'd0);

        // Back-to-back frames at divider 38 (624 clks per bit).
        rx_if.freq_divider = 8'd38;
        wait_clks(100);
        p0 = push_tot; f0 = ferr_tot; o0 = ovr_tot;
        send_byte(8'h00, 1'b1, 624);
        send_byte(8'hFF, 1'b1, 624);
        send_byte(8'h55, 1'b1, 624);
        wait_clks(700);
        check("b2b_push_cnt", 32'(push_tot - p0), 32'd3);
        check("b2b_data0",    32'(rx_log[p0]),     32'h00);
        check("b2b_data1",    32'(rx_log[p0 + 1]), 32'hFF);
        check("b2b_data2",    32'(rx_log[p0 + 2]), 32'h55);

        // Reset in the middle of a fourth frame (start + 3 data bits).
        p0 = push_tot;
        rx_if.rx_bit = 1'b0;
        wait_clks(4 * 624);
        reset = 1'b1;
        wait_clks(2);
        rx_if.rx_bit = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(2 * 624);
        check("midrst_strobes", 32'((push_tot - p0) + (ferr_tot - f0) + (ovr_tot - o0)), 32'd0);
        check("midrst_busy",    32'(rx_if.busy), 32'h0);
        send_byte(8'h12, 1'b1, 624);
        wait_clks(700);
        check("post_rst_push", 32'(push_tot - p0), 32'd1);
        check("post_rst_data", 32'(rx_log[p0]),    32'h12);

        check("strobe_exclusive", 32'(excl_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
